// File: rtl/prime_round_ctrl_pkg.sv
// Shared types and constants for the prime-guessing round controller.
package prime_round_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        SETTLE,
        WAIT_GUESS,
        RESULT,
        DONE
    } state_t;

    // Bit n is set when n is prime (2, 3, 5, 7, 11, 13).
    localparam logic [15:0] PRIME_MASK = 16'h28AC;

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one active-low push button: the filtered level follows the
// raw input only after it has disagreed for DEBOUNCE_CYC consecutive cycles,
// and press pulses for one cycle on each accepted high-to-low change.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (raw_n != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = raw_n;
                press_d = ~raw_n;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset treats the button as released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/prime_round_ctrl.sv
// Round controller for a "is this number prime?" guessing game: draws a
// number from an external generator, waits for a yes/no guess with a timeout,
// scores the round and stops after MAX_ROUNDS rounds.
module prime_round_ctrl
    import prime_round_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 4,
    parameter int GUESS_TIMEOUT = 255,
    parameter int MAX_ROUNDS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_draw_n,
    input  logic       btn_yes_n,
    input  logic       btn_no_n,
    input  logic [3:0] rnd_in,
    output logic       gen_btn_n,
    output logic [3:0] number,
    output logic       result_valid,
    output logic       correct,
    output logic       timeout,
    output logic [3:0] score,
    output logic [3:0] rounds,
    output logic       game_over
);

    localparam int TW = (GUESS_TIMEOUT > 1) ? $clog2(GUESS_TIMEOUT) : 1;

    logic draw_level, draw_press;
    logic yes_level, yes_press;
    logic no_level, no_press;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_draw (
        .clk(clk), .rst(rst), .raw_n(btn_draw_n), .level(draw_level), .press(draw_press)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_yes (
        .clk(clk), .rst(rst), .raw_n(btn_yes_n), .level(yes_level), .press(yes_press)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_no (
        .clk(clk), .rst(rst), .raw_n(btn_no_n), .level(no_level), .press(no_press)
    );

    // Guess buttons act only through their press strobes; levels are dropped here.
    logic unused_guess_levels;
    assign unused_guess_levels = yes_level ^ no_level;

    state_t        state_q, state_d;
    logic          settle_q, settle_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    number_q, number_d;
    logic          correct_q, correct_d;
    logic          timeout_q, timeout_d;
    logic [3:0]    score_q, score_d;
    logic [3:0]    rounds_q, rounds_d;
    logic          gen_btn_n_q, gen_btn_n_d;
    logic          result_valid_q, result_valid_d;
    logic          game_over_q, game_over_d;
    logic          enter_result;

    // Next-state and datapath; round scoring is applied on the edge into RESULT.
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        timer_d      = timer_q;
        number_d     = number_q;
        correct_d    = correct_q;
        timeout_d    = timeout_q;
        score_d      = score_q;
        rounds_d     = rounds_q;
        enter_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (draw_press) state_d = SPIN;
            end
            SPIN: begin
                settle_d = 1'b0;
                if (draw_level) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_q) begin
                    number_d = rnd_in;
                    timer_d  = '0;
                    state_d  = WAIT_GUESS;
                end else begin
                    settle_d = 1'b1;
                end
            end
            WAIT_GUESS: begin
                if (yes_press ^ no_press) begin
                    correct_d    = yes_press ? PRIME_MASK[number_q] : ~PRIME_MASK[number_q];
                    timeout_d    = 1'b0;
                    enter_result = 1'b1;
                end else if (timer_q == TW'(GUESS_TIMEOUT - 1)) begin
                    correct_d    = 1'b0;
                    timeout_d    = 1'b1;
                    enter_result = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (enter_result) begin
                    state_d  = RESULT;
                    rounds_d = rounds_q + 1'b1;
                    if (correct_d && (score_q != 4'hF)) score_d = score_q + 1'b1;
                end
            end
            RESULT: begin
                state_d = (int'(rounds_q) >= MAX_ROUNDS) ? DONE : IDLE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        gen_btn_n_d    = (state_d != SPIN);
        result_valid_d = (state_d == RESULT);
        game_over_d    = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            settle_q       <= 1'b0;
            timer_q        <= '0;
            number_q       <= '0;
            correct_q      <= 1'b0;
            timeout_q      <= 1'b0;
            score_q        <= '0;
            rounds_q       <= '0;
            gen_btn_n_q    <= 1'b1;
            result_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            timer_q        <= timer_d;
            number_q       <= number_d;
            correct_q      <= correct_d;
            timeout_q      <= timeout_d;
            score_q        <= score_d;
            rounds_q       <= rounds_d;
            gen_btn_n_q    <= gen_btn_n_d;
            result_valid_q <= result_valid_d;
            game_over_q    <= game_over_d;
        end
    end

    assign gen_btn_n    = gen_btn_n_q;
    assign number       = number_q;
    assign result_valid = result_valid_q;
    assign correct      = correct_q;
    assign timeout      = timeout_q;
    assign score        = score_q;
    assign rounds       = rounds_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_prime_round_ctrl.sv
// Scoreboard bench for prime_round_ctrl: stimulus pushes expected round
// results, a negedge monitor pops and compares on every result_valid.
module tb_prime_round_ctrl;

    localparam int DEB  = 4;
    localparam int TMO  = 255;
    localparam int MAXR = 2;

    logic       clk;
    logic       rst;
    logic       btn_draw_n, btn_yes_n, btn_no_n;
    logic [3:0] rnd_in;
    logic       gen_btn_n;
    logic [3:0] number;
    logic       result_valid, correct, timeout;
    logic [3:0] score, rounds;
    logic       game_over;

    prime_round_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .GUESS_TIMEOUT(TMO),
        .MAX_ROUNDS   (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_draw_n  (btn_draw_n),
        .btn_yes_n   (btn_yes_n),
        .btn_no_n    (btn_no_n),
        .rnd_in      (rnd_in),
        .gen_btn_n   (gen_btn_n),
        .number      (number),
        .result_valid(result_valid),
        .correct     (correct),
        .timeout     (timeout),
        .score       (score),
        .rounds      (rounds),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       correct;
        logic       timeout;
        logic [3:0] number;
        logic [3:0] score;
        logic [3:0] rounds;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_score = 0;
    int   m_rounds = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: every result strobe must match the oldest expected round.
    always @(negedge clk) begin
        exp_t e;
        if (rst && result_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("correct", correct, e.correct);
                chk("timeout", timeout, e.timeout);
                chk("number", number, e.number);
                chk("score", score, e.score);
                chk("rounds", rounds, e.rounds);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_draw_n = 1'b1; btn_yes_n = 1'b1; btn_no_n = 1'b1;
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        sb_q.delete();
        m_score  = 0;
        m_rounds = 0;
    endtask

    // Hold draw for h cycles; rnd_in carries val only on the cycle the
    // generator value must be captured, junk otherwise.
    task automatic draw(input int h, input logic [3:0] val, output int low_cnt);
        low_cnt = 0;
        for (int i = 0; i < h + 12; i++) begin
            @(negedge clk);
            if (!gen_btn_n) low_cnt++;
            btn_draw_n = (i < h) ? 1'b0 : 1'b1;
            rnd_in     = (i == h + 6) ? val : ~val;
        end
    endtask

    // which: 0 = yes, 1 = no, 2 = both together
    task automatic guess(input int which);
        @(negedge clk);
        btn_yes_n = (which == 1);
        btn_no_n  = (which == 0);
        cyc(6);
        btn_yes_n = 1'b1;
        btn_no_n  = 1'b1;
        cyc(8);
    endtask

    // g: 0 = yes, 1 = no, 2 = let it time out
    task automatic play_round(input int h, input logic [3:0] val, input int g, input bit both_first);
        int   low;
        int   n;
        exp_t e;
        draw(h, val, low);
        chk("gen_btn_low_cycles", low, h);
        if (both_first) begin
            guess(2);
            chk("both_ignored_rounds", rounds, m_rounds);
            chk("both_ignored_go", game_over, 0);
        end
        e.number  = val;
        e.timeout = (g == 2);
        e.correct = (g == 0) ? is_prime(val) : (g == 1) ? !is_prime(val) : 1'b0;
        m_rounds++;
        if (e.correct && m_score < 15) m_score++;
        e.score  = 4'(m_score);
        e.rounds = 4'(m_rounds);
        sb_q.push_back(e);
        if (g == 2) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!result_valid && n < 400);
            chk("timeout_latency", n, TMO - 4);
            cyc(10);
        end else begin
            guess(g);
        end
        chk("sb_drained", sb_q.size(), 0);
        chk("game_over", game_over, (m_rounds >= MAXR) ? 1 : 0);
        chk("number_held", number, val);
    endtask

    initial begin
        int low;
        rst = 1'b0;
        btn_draw_n = 1'b1; btn_yes_n = 1'b1; btn_no_n = 1'b1;
        rnd_in = 4'h0;
        cyc(3);
        chk("rst_number", number, 0);
        chk("rst_score", score, 0);
        chk("rst_rounds", rounds, 0);
        chk("rst_gen_btn_n", gen_btn_n, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_correct", correct, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;

        // Short draw glitch and idle guesses must do nothing.
        draw(3, 4'd5, low);
        chk("glitch_gen_low", low, 0);
        chk("glitch_number", number, 0);
        guess(0);
        guess(1);
        chk("idle_guess_rounds", rounds, 0);

        // Game A: prime with yes, then non-prime with yes, then DONE.
        play_round(10, 4'd7, 0, 1'b1);
        play_round(10, 4'd9, 0, 1'b0);
        draw(10, 4'd3, low);
        chk("done_gen_low", low, 0);
        guess(0);
        chk("done_game_over", game_over, 1);
        chk("done_rounds", rounds, 2);
        chk("done_number", number, 9);

        // Game B: score a point, then reset while waiting for a guess.
        do_reset();
        play_round(8, 4'd13, 0, 1'b0);
        draw(10, 4'd4, low);
        chk("pre_reset_score", score, 1);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_number", number, 0);
        chk("mid_rst_rounds", rounds, 0);
        chk("mid_rst_gen_btn_n", gen_btn_n, 1);
        rst = 1'b1;
        m_score  = 0;
        m_rounds = 0;
        play_round(10, 4'd2, 1, 1'b0);
        play_round(12, 4'd11, 2, 1'b0);
        cyc(5);
        chk("timeout_held", timeout, 1);
        chk("correct_held", correct, 0);

        // Randomised games.
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int r = 0; r < MAXR; r++)
                play_round(int'($urandom_range(5, 15)), 4'($urandom_range(0, 15)),
                           int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/prime_round_ctrl.md
PRIME_ROUND_CTRL -- requirements
Module: prime_round_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 4: consecutive stable cycles before a button level change is accepted.
REQ-002 SHALL have parameter GUESS_TIMEOUT, default 255: cycles allowed for a guess.
REQ-003 SHALL have parameter MAX_ROUNDS, default 10: rounds per game.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port btn_draw_n  in  1  draw button, active-low.
REQ-007 SHALL have port btn_yes_n  in  1  "prime" guess button, active-low.
REQ-008 SHALL have port btn_no_n  in  1  "not prime" guess button, active-low.
REQ-009 SHALL have port rnd_in  in  4  random number generator output.
REQ-010 SHALL have port gen_btn_n  out  1  random number generator button drive, active-low.
REQ-011 SHALL have port number  out  4  captured number.
REQ-012 SHALL have port result_valid  out  1  one-cycle round-result strobe.
REQ-013 SHALL have port correct  out  1  guess correct; valid with result_valid.
REQ-014 SHALL have port timeout  out  1  round ended by timeout; valid with result_valid.
REQ-015 SHALL have port score  out  4  correct rounds, saturating at 15.
REQ-016 SHALL have port rounds  out  4  completed rounds.
REQ-017 SHALL have port game_over  out  1  high in DONE.

Function
REQ-018 SHALL debounce each button: the debounced level changes only after the raw level differs from it for DEBOUNCE_CYC consecutive cycles; a press event is a debounced high-to-low transition.
REQ-019 SHALL implement states IDLE, SPIN, SETTLE, WAIT_GUESS, RESULT, DONE.
REQ-020 IDLE: on a draw press event, SHALL go to SPIN; guess events SHALL be ignored.
REQ-021 SPIN: SHALL drive gen_btn_n=0, registered from state; on debounced draw release, SHALL go to SETTLE.
REQ-022 gen_btn_n SHALL be 1 in every state other than SPIN.
REQ-023 SETTLE: SHALL last exactly 2 cycles, then load number<=rnd_in and go to WAIT_GUESS.
REQ-024 WAIT_GUESS: on a yes-only event, correct SHALL equal PRIME_MASK[number]; on a no-only event, correct SHALL equal ~PRIME_MASK[number]; either SHALL go to RESULT.
REQ-025 WAIT_GUESS: yes and no events in the same cycle SHALL both be ignored and the state held; draw events SHALL be ignored.
REQ-026 WAIT_GUESS: a cycle counter SHALL clear on entry; if no guess arrives within GUESS_TIMEOUT cycles, SHALL go to RESULT with correct=0, timeout=1.
REQ-027 RESULT: SHALL last 1 cycle with result_valid=1; score+=correct, saturating at 15; rounds+=1.
REQ-028 RESULT: SHALL go to DONE when rounds reaches MAX_ROUNDS, else to IDLE.
REQ-029 correct and timeout SHALL hold their values until the next RESULT.
REQ-030 DONE: game_over=1; SHALL ignore all buttons; SHALL leave only by reset.
REQ-031 Guess presses made before WAIT_GUESS is entered SHALL NOT count; only press events occurring in WAIT_GUESS count.

Reset
REQ-032 rst=0 at a clk edge, in any state, SHALL force IDLE.
REQ-033 rst=0 at a clk edge SHALL force number=0, score=0, rounds=0, correct=0, timeout=0, result_valid=0, game_over=0, gen_btn_n=1.
REQ-034 rst=0 at a clk edge SHALL set the debounced levels to released (1) and clear the debounce and timeout counters.

Structure
REQ-035 A shared package SHALL hold the state enum and PRIME_MASK = 16'h28AC (primes 2, 3, 5, 7, 11, 13).
REQ-036 Sub-module btn_debounce (parameter DEBOUNCE_CYC; outputs level and press strobe) SHALL be instantiated three times.

Verification
REQ-037 Draw held 10 cycles then released, rnd_in=7, yes pressed -> gen_btn_n low only in SPIN; number=7; correct=1; score=1; rounds=1.
REQ-038 rnd_in=9, yes pressed -> correct=0; score unchanged; rounds increments.
REQ-039 No guess for 255 cycles -> result_valid pulse with timeout=1, correct=0.
REQ-040 Draw glitch low for 3 cycles (DEBOUNCE_CYC=4) -> stays IDLE, gen_btn_n=1; yes and no pressed in the same cycle -> stays in WAIT_GUESS.
REQ-041 MAX_ROUNDS=2, two rounds played -> game_over=1; a further draw press is ignored.
REQ-042 rst=0 during WAIT_GUESS with score=1 -> IDLE; score=0, number=0, rounds=0.
